// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the IF fetch sequencer: FSM state encoding, MUX_IF
// source selects and the per-cycle command bundle produced by the decoder.
package if_fetch_ctrl_pkg;

   localparam logic [1:0] ST_BOOT      = 2'b00;
   localparam logic [1:0] ST_RUN       = 2'b01;
   localparam logic [1:0] ST_JMPL_PEND = 2'b10;

   localparam logic [1:0] SEL_NPC = 2'b00;
   localparam logic [1:0] SEL_TA  = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;

   // One cycle's worth of fetch-stage control; le drives PC, nPC and IF/ID together.
   typedef struct packed {
      logic       le;
      logic       clear;
      logic [1:0] sel;
      logic       stall_inc;
      logic       flush_inc;
   } fetch_cmd_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Control bundle between the fetch sequencer (master) and the IF datapath,
// hazard unit and branch resolution logic (slave side).
interface if_fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             hz_stall;
   logic             br_id;
   logic             br_taken;
   logic             br_uncond;
   logic             annul_id;
   logic             jmpl_ex;
   logic [31:0]      ta_id;
   logic [31:0]      alu_out;

   logic             pc_le;
   logic             npc_le;
   logic             ifid_le;
   logic             ch_clear;
   logic [1:0]       mux_sel;
   logic [31:0]      redir_addr;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  hz_stall, br_id, br_taken, br_uncond, annul_id, jmpl_ex, ta_id, alu_out,
      output pc_le, npc_le, ifid_le, ch_clear, mux_sel, redir_addr, stall_cnt, flush_cnt
   );

   modport slave (
      output hz_stall, br_id, br_taken, br_uncond, annul_id, jmpl_ex, ta_id, alu_out,
      input  pc_le, npc_le, ifid_le, ch_clear, mux_sel, redir_addr, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/if_fetch_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping, cleared by R.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             R,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: registered state is always written with <= so every flop samples
   // the pre-edge value of its inputs, independent of block ordering.
   always_ff @(posedge clk) begin
      if (R) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: decodes stalls, ID branch resolution and EX jmpl
// into PC/nPC/IF-ID enables, the IF/ID squash and the MUX_IF select.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int BOOT_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input logic           clk,
   input logic           R,
   if_fetch_ctrl_if.master bus
);

   localparam int             BW        = $clog2(BOOT_CYCLES + 1);
   localparam logic [BW-1:0]  BOOT_LAST = BW'(BOOT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] boot_q, boot_d;
   logic [31:0]   tgt_q, tgt_d;
   logic [31:0]   redir;
   fetch_cmd_t    cmd;

   // NOTE: every variable assigned below gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      cmd       = '0;
      cmd.sel   = SEL_NPC;
      redir     = '0;
      state_d   = state_q;
      boot_d    = boot_q;
      tgt_d     = tgt_q;

      case (state_q)
         ST_BOOT: begin
            if (boot_q == BOOT_LAST) begin
               state_d = ST_RUN;
            end else begin
               boot_d = boot_q + 1'b1;
            end
         end

         ST_RUN: begin
            redir = bus.ta_id;
            if (bus.jmpl_ex && !bus.hz_stall) begin
               // The delay slot is already in ID; only the fetch behind it dies.
               cmd.le        = 1'b1;
               cmd.clear     = 1'b1;
               cmd.sel       = SEL_ALU;
               cmd.flush_inc = 1'b1;
            end else if (bus.jmpl_ex) begin
               cmd.stall_inc = 1'b1;
               tgt_d         = bus.alu_out;
               state_d       = ST_JMPL_PEND;
            end else if (bus.hz_stall) begin
               cmd.stall_inc = 1'b1;
            end else begin
               cmd.le = 1'b1;
               if (bus.br_id) begin
                  if (bus.br_taken) begin
                     cmd.sel   = SEL_TA;
                     cmd.clear = bus.annul_id && bus.br_uncond;
                  end else begin
                     cmd.clear = bus.annul_id;
                  end
                  cmd.flush_inc = cmd.clear;
               end
            end
         end

         ST_JMPL_PEND: begin
            // EX has moved on, so the captured target replaces alu_out.
            redir = tgt_q;
            if (bus.hz_stall) begin
               cmd.stall_inc = 1'b1;
            end else begin
               cmd.le        = 1'b1;
               cmd.clear     = 1'b1;
               cmd.sel       = SEL_TA;
               cmd.flush_inc = 1'b1;
               state_d       = ST_RUN;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase

      if (R) begin
         cmd   = '0;
         redir = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (R) begin
         state_q <= ST_BOOT;
         boot_q  <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         tgt_q   <= tgt_d;
      end
   end

   assign bus.pc_le      = cmd.le;
   assign bus.npc_le     = cmd.le;
   assign bus.ifid_le    = cmd.le;
   assign bus.ch_clear   = cmd.clear;
   assign bus.mux_sel    = cmd.sel;
   assign bus.redir_addr = redir;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .R     (R),
      .inc   (cmd.stall_inc),
      .count (bus.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .R     (R),
      .inc   (cmd.flush_inc),
      .count (bus.flush_cnt)
   );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small PC/nPC datapath model that
// follows the DUT enables so fetch addresses can be checked end to end.
module tb_if_fetch_ctrl;

   localparam int BOOT_CYCLES = 2;
   localparam int CNT_W       = 4;

   logic clk;
   logic R;
   int   n_checks = 0;
   int   n_fail   = 0;

   if_fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

   if_fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IF datapath model: PC/nPC registers behind MUX_IF.
   logic [31:0] pc, npc, mux_out;
   always_comb begin
      case (bus.mux_sel)
         2'b01:   mux_out = bus.redir_addr;
         2'b10:   mux_out = bus.alu_out;
         default: mux_out = npc;
      endcase
   end

   always @(posedge clk) begin
      if (R) begin
         pc  <= 32'h0;
         npc <= 32'h4;
      end else begin
         if (bus.pc_le)  pc  <= mux_out;
         if (bus.npc_le) npc <= mux_out + 32'h4;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.hz_stall  = 1'b0;
      bus.br_id     = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_uncond = 1'b0;
      bus.annul_id  = 1'b0;
      bus.jmpl_ex   = 1'b0;
      bus.ta_id     = 32'h0;
      bus.alu_out   = 32'h0;
   endtask

   // Leaves the bench in the first RUN cycle.
   task automatic do_reset();
      R = 1'b1;
      idle();
      tick();
      R = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      R = 1'b1;
      idle();

      // Reset and boot delay
      tick(); #1;
      check("rst_pc_le", bus.pc_le, 1'b0);
      check("rst_clear", bus.ch_clear, 1'b0);
      check("rst_sel", bus.mux_sel, 2'b00);
      check("rst_redir", bus.redir_addr, 32'h0);
      check("rst_stall_cnt", bus.stall_cnt, 4'd0);
      check("rst_flush_cnt", bus.flush_cnt, 4'd0);
      tick();
      R = 1'b0; #1;
      check("boot1_pc_le", bus.pc_le, 1'b0);
      tick(); #1;
      check("boot2_pc_le", bus.pc_le, 1'b0);
      tick(); #1;
      check("run_pc_le", bus.pc_le, 1'b1);
      check("pc0", pc, 32'h0);
      tick(); #1; check("pc4", pc, 32'h4);
      tick(); #1; check("pc8", pc, 32'h8);

      // Taken branch, no annul
      bus.br_id = 1'b1; bus.br_taken = 1'b1; bus.ta_id = 32'h40; #1;
      check("tk_sel", bus.mux_sel, 2'b01);
      check("tk_redir", bus.redir_addr, 32'h40);
      check("tk_clear", bus.ch_clear, 1'b0);
      tick(); idle(); #1;
      check("tk_next_sel", bus.mux_sel, 2'b00);
      check("tk_pc40", pc, 32'h40);
      tick(); #1; check("tk_pc44", pc, 32'h44);

      // Untaken with annul squashes the delay slot
      bus.br_id = 1'b1; bus.annul_id = 1'b1; #1;
      check("ua_sel", bus.mux_sel, 2'b00);
      check("ua_clear", bus.ch_clear, 1'b1);
      tick(); idle(); #1;
      check("ua_flush_cnt", bus.flush_cnt, 4'd1);
      check("ua_pc48", pc, 32'h48);

      // ba,a: taken, unconditional, annulled
      bus.br_id = 1'b1; bus.br_taken = 1'b1; bus.br_uncond = 1'b1;
      bus.annul_id = 1'b1; bus.ta_id = 32'h80; #1;
      check("baa_sel", bus.mux_sel, 2'b01);
      check("baa_clear", bus.ch_clear, 1'b1);
      tick(); idle(); #1;
      check("baa_flush_cnt", bus.flush_cnt, 4'd2);
      check("baa_pc80", pc, 32'h80);

      // Conditional taken with annul executes the delay slot
      bus.br_id = 1'b1; bus.br_taken = 1'b1; bus.annul_id = 1'b1; bus.ta_id = 32'hC0; #1;
      check("bca_clear", bus.ch_clear, 1'b0);
      tick(); idle(); #1;
      check("bca_flush_cnt", bus.flush_cnt, 4'd2);
      check("bca_pcC0", pc, 32'hC0);

      // jmpl without stall; simultaneous br_id is ignored
      bus.jmpl_ex = 1'b1; bus.alu_out = 32'h200;
      bus.br_id = 1'b1; bus.br_taken = 1'b1; bus.ta_id = 32'h40; #1;
      check("jm_sel", bus.mux_sel, 2'b10);
      check("jm_clear", bus.ch_clear, 1'b1);
      tick(); idle(); #1;
      check("jm_flush_cnt", bus.flush_cnt, 4'd3);
      check("jm_pc200", pc, 32'h200);

      // jmpl under a three-cycle stall
      do_reset(); #1;
      check("r2_stall_cnt", bus.stall_cnt, 4'd0);
      check("r2_flush_cnt", bus.flush_cnt, 4'd0);
      check("r2_pc0", pc, 32'h0);
      bus.jmpl_ex = 1'b1; bus.hz_stall = 1'b1; bus.alu_out = 32'h100; #1;
      check("js0_pc_le", bus.pc_le, 1'b0);
      check("js0_ifid_le", bus.ifid_le, 1'b0);
      tick();
      bus.jmpl_ex = 1'b0; bus.alu_out = 32'hDEAD;
      bus.br_id = 1'b1; bus.br_taken = 1'b1; bus.ta_id = 32'h40; #1;
      check("js1_pc_le", bus.pc_le, 1'b0);
      tick(); #1;
      check("js2_pc_le", bus.pc_le, 1'b0);
      tick();
      bus.hz_stall = 1'b0; #1;
      check("js_sel", bus.mux_sel, 2'b01);
      check("js_redir", bus.redir_addr, 32'h100);
      check("js_clear", bus.ch_clear, 1'b1);
      check("js_npc_le", bus.npc_le, 1'b1);
      check("js_stall_cnt", bus.stall_cnt, 4'd3);
      tick(); idle(); #1;
      check("js_flush_cnt", bus.flush_cnt, 4'd1);
      check("js_pc100", pc, 32'h100);
      check("js_after_sel", bus.mux_sel, 2'b00);

      // Reset while a jmpl target is pending
      bus.jmpl_ex = 1'b1; bus.hz_stall = 1'b1; bus.alu_out = 32'h300;
      tick();
      bus.jmpl_ex = 1'b0; #1;
      check("rp_stall_cnt", bus.stall_cnt, 4'd4);
      R = 1'b1; idle(); #1;
      check("rp_pc_le", bus.pc_le, 1'b0);
      check("rp_sel", bus.mux_sel, 2'b00);
      check("rp_redir", bus.redir_addr, 32'h0);
      tick(); #1;
      check("rp_stall_clr", bus.stall_cnt, 4'd0);
      check("rp_flush_clr", bus.flush_cnt, 4'd0);
      R = 1'b0;
      tick();
      tick(); #1;
      check("rp_run_pc_le", bus.pc_le, 1'b1);
      check("rp_run_sel", bus.mux_sel, 2'b00);
      check("rp_run_clear", bus.ch_clear, 1'b0);
      check("rp_pc0", pc, 32'h0);
      tick(); #1;
      check("rp_pc4", pc, 32'h4);

      // Stall counter saturation
      bus.hz_stall = 1'b1;
      repeat (20) tick();
      #1;
      check("sat_pc_le", bus.pc_le, 1'b0);
      check("sat_stall_cnt", bus.stall_cnt, 4'd15);
      tick(); #1;
      check("sat_hold", bus.stall_cnt, 4'd15);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
